// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; results commit after a fixed per-class latency.
// Optional flush-cancel of in-flight/issuing ops is enabled with `define MDU_CANCEL_EN.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q, p_wr_q;
    logic [31:0]   hi_q, lo_q, p_hi_q, p_lo_q;

    logic          kill;
`ifdef MDU_CANCEL_EN
    assign kill = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign kill = 1'b0;
`endif

    // Division works on magnitudes so 0x80000000 / -1 yields 0x80000000 with no overflow trap.
    logic          is_div, div_zero, a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag;
    logic signed [63:0] prod_s;
    logic [63:0]   prod_u;
    logic [31:0]   res_hi, res_lo;
    logic [CW-1:0] lat;

    always_comb begin
        is_div   = md_op[1];
        div_zero = (B == 32'd0);
        a_neg    = (md_op == 3'd2) && A[31];
        b_neg    = (md_op == 3'd2) && B[31];
        a_mag    = a_neg ? (32'd0 - A) : A;
        b_mag    = b_neg ? (32'd0 - B) : B;
        q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
        r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
        prod_s   = $signed(A) * $signed(B);
        prod_u   = {32'd0, A} * {32'd0, B};
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        case (md_op)
            3'd0: {res_hi, res_lo} = prod_s;
            3'd1: {res_hi, res_lo} = prod_u;
            3'd2, 3'd3: begin
                res_lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
                res_hi = a_neg ? (32'd0 - r_mag) : r_mag;
            end
            default: ;
        endcase
        lat = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            p_wr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !kill) begin
                        if (md_op < 3'd4) begin
                            p_hi_q  <= res_hi;
                            p_lo_q  <= res_lo;
                            p_wr_q  <= !(is_div && div_zero);
                            cnt_q   <= lat;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else if (md_op == 3'd4) begin
                            hi_q <= A;
                        end else if (md_op == 3'd5) begin
                            lo_q <= A;
                        end
                    end
                end
                RUN: begin
                    if (kill) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == CW'(1)) begin
                        if (p_wr_q) begin
                            hi_q <= p_hi_q;
                            lo_q <= p_lo_q;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign stall_req = busy_q | (start & (md_op < 3'd4));
    assign HI        = hi_q;
    assign LO        = lo_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer (default latencies 5/10).
// Flush expectations follow whether MDU_CANCEL_EN is defined for the build.
module tb_mdu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd7;
    logic [31:0] A = '0, B = '0;
    logic        flush = 1'b0;
    logic        busy, stall_req;
    logic [31:0] HI, LO;

    int tests = 0;
    int fails = 0;

    mdu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .A(A), .B(B),
        .flush(flush), .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Called at a negedge; drives one request for one cycle and returns at the next negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic sr);
        start = 1'b1; md_op = op; A = a; B = b;
        #1 sr = stall_req;
        @(negedge clk);
        start = 1'b0; md_op = 3'd7;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || stall_req !== 1'b0) begin
            fails++;
            $display("FAIL reset: busy=%b stall=%b HI=%h LO=%h, want 0/0/0/0", busy, stall_req, HI, LO);
        end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
    endtask

    task automatic test_mult;
        logic sr; int n;
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, sr);
        tests++;
        if (sr !== 1'b1) begin fails++; $display("FAIL mult_stall_req: got %b want 1", sr); end
        tests++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            fails++; $display("FAIL mult_old_hilo: HI=%h LO=%h want 0/0 during RUN", HI, LO);
        end
        wait_idle(n);
        tests++;
        if (n !== 5) begin fails++; $display("FAIL mult_busy_len: got %0d want 5", n); end
        tests++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
            fails++; $display("FAIL mult_result: HI=%h LO=%h want ffffffff/fffffffa", HI, LO);
        end
    endtask

    task automatic test_multu;
        logic sr; int n;
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, sr);
        wait_idle(n);
        tests++;
        if (n !== 5 || HI !== 32'h2 || LO !== 32'hFFFF_FFFA) begin
            fails++; $display("FAIL multu: len=%0d HI=%h LO=%h want 5 00000002/fffffffa", n, HI, LO);
        end
    endtask

    task automatic test_div;
        logic sr; int n;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, sr);
        wait_idle(n);
        tests++;
        if (n !== 10 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            fails++; $display("FAIL div_neg: len=%0d HI=%h LO=%h want 10 ffffffff/fffffffd", n, HI, LO);
        end
        issue(3'd2, 32'd7, 32'hFFFF_FFFE, sr);
        wait_idle(n);
        tests++;
        if (HI !== 32'd1 || LO !== 32'hFFFF_FFFD) begin
            fails++; $display("FAIL div_negdivisor: HI=%h LO=%h want 00000001/fffffffd", HI, LO);
        end
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, sr);
        wait_idle(n);
        tests++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
            fails++; $display("FAIL div_overflow: HI=%h LO=%h want 00000000/80000000", HI, LO);
        end
    endtask

    task automatic test_div_zero;
        logic sr; int n;
        issue(3'd3, 32'd100, 32'd7, sr);
        wait_idle(n);
        tests++;
        if (HI !== 32'd2 || LO !== 32'd14) begin
            fails++; $display("FAIL divu: HI=%h LO=%h want 00000002/0000000e", HI, LO);
        end
        issue(3'd3, 32'd7, 32'd0, sr);
        wait_idle(n);
        tests++;
        if (n !== 10 || HI !== 32'd2 || LO !== 32'd14) begin
            fails++; $display("FAIL divu_zero: len=%0d HI=%h LO=%h want 10 00000002/0000000e", n, HI, LO);
        end
    endtask

    task automatic test_mthi_mtlo;
        logic sr;
        issue(3'd4, 32'h1234, 32'd0, sr);
        tests++;
        if (sr !== 1'b0 || busy !== 1'b0 || HI !== 32'h1234 || LO !== 32'd14) begin
            fails++; $display("FAIL mthi: stall=%b busy=%b HI=%h LO=%h want 0 0 00001234/0000000e", sr, busy, HI, LO);
        end
        issue(3'd5, 32'h5678, 32'd0, sr);
        tests++;
        if (busy !== 1'b0 || HI !== 32'h1234 || LO !== 32'h5678) begin
            fails++; $display("FAIL mtlo: busy=%b HI=%h LO=%h want 0 00001234/00005678", busy, HI, LO);
        end
    endtask

    task automatic test_back_to_back;
        logic sr; int n;
        issue(3'd3, 32'd100, 32'd7, sr);
        wait_idle(n);
        // Same cycle busy fell: results already visible, next op issues immediately.
        tests++;
        if (n !== 10 || HI !== 32'd2 || LO !== 32'd14) begin
            fails++; $display("FAIL b2b_first: len=%0d HI=%h LO=%h want 10 00000002/0000000e", n, HI, LO);
        end
        issue(3'd0, 32'd6, 32'd7, sr);
        wait_idle(n);
        tests++;
        if (n !== 5 || HI !== 32'd0 || LO !== 32'd42) begin
            fails++; $display("FAIL b2b_second: len=%0d HI=%h LO=%h want 5 00000000/0000002a", n, HI, LO);
        end
    endtask

    task automatic test_start_ignored;
        logic sr; int n;
        issue(3'd0, 32'd3, 32'd4, sr);
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; A = 32'd100; B = 32'd3;
        @(negedge clk);
        start = 1'b0; md_op = 3'd7;
        wait_idle(n);
        tests++;
        if (n + 2 !== 5 || HI !== 32'd0 || LO !== 32'd12) begin
            fails++; $display("FAIL start_ignored: len=%0d HI=%h LO=%h want 5 00000000/0000000c", n + 2, HI, LO);
        end
    endtask

    task automatic test_flush;
        logic sr; int n;
        issue(3'd2, 32'd1000, 32'd10, sr);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
`ifdef MDU_CANCEL_EN
        tests++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd12) begin
            fails++; $display("FAIL flush_cancel: busy=%b HI=%h LO=%h want 0 00000000/0000000c", busy, HI, LO);
        end
        start = 1'b1; md_op = 3'd4; A = 32'hBEEF; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = 3'd7; flush = 1'b0;
        tests++;
        if (busy !== 1'b0 || HI !== 32'd0) begin
            fails++; $display("FAIL flush_suppress: busy=%b HI=%h want 0 00000000", busy, HI);
        end
`else
        wait_idle(n);
        tests++;
        if (n + 3 !== 10 || HI !== 32'd0 || LO !== 32'h64) begin
            fails++; $display("FAIL flush_ignored: len=%0d HI=%h LO=%h want 10 00000000/00000064", n + 3, HI, LO);
        end
        start = 1'b1; md_op = 3'd4; A = 32'hBEEF; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = 3'd7; flush = 1'b0;
        tests++;
        if (HI !== 32'hBEEF) begin
            fails++; $display("FAIL flush_ignored_mthi: HI=%h want 0000beef", HI);
        end
`endif
    endtask

    task automatic test_async_reset;
        logic sr;
        issue(3'd4, 32'hAAAA, 32'd0, sr);
        issue(3'd0, 32'd5, 32'd5, sr);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            fails++; $display("FAIL async_reset: busy=%b HI=%h LO=%h want 0 0/0", busy, HI, LO);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        tests++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            fails++; $display("FAIL post_reset: busy=%b HI=%h LO=%h want 0 0/0", busy, HI, LO);
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_multu;
        test_div;
        test_div_zero;
        test_mthi_mtlo;
        test_back_to_back;
        test_start_ignored;
        test_flush;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
